// File: rtl/decryption_pkg.sv
// Shared types and constants for the decryption front-end.
//   state_t      : scheduler FSM states
//   SEL_*        : algorithm / output-mux select codes
//   DEF_*        : default data width and end-of-message marker
package decryption_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [1:0] SEL_CAESAR  = 2'd0;
    localparam logic [1:0] SEL_SCYTALE = 2'd1;
    localparam logic [1:0] SEL_ZIGZAG  = 2'd2;
    localparam logic [1:0] SEL_NONE    = 2'd3;

    localparam int         DEF_D_WIDTH    = 8;
    localparam logic [7:0] DEF_TERMINATOR = 8'hFA;

endpackage

// File: rtl/drain_watchdog.sv
// Clearable, enabled up-counter with a terminal-count flag.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear to 0 (has priority over en_i)
//   en_i       : count enable
//   tc_o       : high while enabled and the count equals TIMEOUT-1, i.e.
//                during the TIMEOUT-th enabled cycle after a clear
module drain_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    assign tc_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !tc_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/decryption_scheduler.sv
// Front-end scheduler: routes each message to one of three decryptors,
// back-pressures the source while that decryptor drains, and drives the
// output mux select. All outputs are registered.
//   data_i/valid_i/select_i : encrypted byte stream and per-message algorithm
//   busy_o                  : source must hold off while high
//   dataN_o/validN_o        : decryptor inputs (0 Caesar, 1 Scytale, 2 ZigZag)
//   busyN_i                 : decryptor busy while emitting plaintext
//   mux_select_o            : output mux select, 3 = disabled
//   msg_len_o               : length of last routed message incl. terminator
//   err_o                   : one-cycle error pulse (bad select, dropped byte,
//                             drain timeout)
module decryption_scheduler
    import decryption_pkg::*;
#(
    parameter int                 D_WIDTH    = DEF_D_WIDTH,
    parameter logic [D_WIDTH-1:0] TERMINATOR = D_WIDTH'(DEF_TERMINATOR),
    parameter int                 LEN_W      = 8,
    parameter int                 TIMEOUT    = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [D_WIDTH-1:0] data_i,
    input  logic               valid_i,
    input  logic [1:0]         select_i,
    output logic               busy_o,
    output logic [D_WIDTH-1:0] data0_o,
    output logic               valid0_o,
    output logic [D_WIDTH-1:0] data1_o,
    output logic               valid1_o,
    output logic [D_WIDTH-1:0] data2_o,
    output logic               valid2_o,
    input  logic               busy0_i,
    input  logic               busy1_i,
    input  logic               busy2_i,
    output logic [1:0]         mux_select_o,
    output logic [LEN_W-1:0]   msg_len_o,
    output logic               err_o
);
    // state | meaning
    // IDLE  | waiting for first byte of a message
    // ROUTE | forwarding bytes to the latched decryptor
    // DRAIN | terminator sent, waiting for decryptor busy rise then fall
    // FLUSH | one cycle for the last plaintext byte to cross the mux

    state_t           state_q, state_n;
    logic [1:0]       sel_q, sel_n, fwd_sel;
    logic [LEN_W-1:0] len_q, len_n, msg_len_n;
    logic             seen_q, seen_n;
    logic             err_n, fwd, busy_sel, wd_tc;

    always_comb begin
        case (sel_q)
            SEL_CAESAR:  busy_sel = busy0_i;
            SEL_SCYTALE: busy_sel = busy1_i;
            SEL_ZIGZAG:  busy_sel = busy2_i;
            default:     busy_sel = 1'b0;
        endcase
    end

    drain_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q != DRAIN),
        .en_i  (state_q == DRAIN),
        .tc_o  (wd_tc)
    );

    always_comb begin
        state_n   = state_q;
        sel_n     = sel_q;
        len_n     = len_q;
        msg_len_n = msg_len_o;
        seen_n    = seen_q;
        err_n     = 1'b0;
        fwd       = 1'b0;
        fwd_sel   = sel_q;
        case (state_q)
            IDLE: begin
                seen_n = 1'b0;
                if (valid_i) begin
                    if (select_i == SEL_NONE) begin
                        err_n = 1'b1;
                    end else begin
                        fwd     = 1'b1;
                        fwd_sel = select_i;
                        sel_n   = select_i;
                        len_n   = LEN_W'(1);
                        if (data_i == TERMINATOR) begin
                            msg_len_n = LEN_W'(1);
                            state_n   = DRAIN;
                        end else begin
                            state_n = ROUTE;
                        end
                    end
                end
            end
            ROUTE: begin
                if (valid_i) begin
                    fwd   = 1'b1;
                    len_n = (len_q == '1) ? len_q : len_q + LEN_W'(1);
                    if (data_i == TERMINATOR) begin
                        msg_len_n = len_n;
                        state_n   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (valid_i) err_n = 1'b1;
                if (busy_sel) seen_n = 1'b1;
                // completion wins over a timeout landing on the same cycle
                if (seen_q && !busy_sel) begin
                    state_n = FLUSH;
                end else if (wd_tc) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            FLUSH: begin
                if (valid_i) err_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= SEL_NONE;
            len_q        <= '0;
            seen_q       <= 1'b0;
            msg_len_o    <= '0;
            err_o        <= 1'b0;
            busy_o       <= 1'b0;
            mux_select_o <= SEL_NONE;
            data0_o      <= '0;
            valid0_o     <= 1'b0;
            data1_o      <= '0;
            valid1_o     <= 1'b0;
            data2_o      <= '0;
            valid2_o     <= 1'b0;
        end else begin
            state_q      <= state_n;
            sel_q        <= sel_n;
            len_q        <= len_n;
            seen_q       <= seen_n;
            msg_len_o    <= msg_len_n;
            err_o        <= err_n;
            // outputs follow the next state so they line up with it
            busy_o       <= (state_n == DRAIN) || (state_n == FLUSH);
            mux_select_o <= (state_n == IDLE) ? SEL_NONE : sel_n;
            valid0_o     <= fwd && (fwd_sel == SEL_CAESAR);
            data0_o      <= (fwd && (fwd_sel == SEL_CAESAR))  ? data_i : '0;
            valid1_o     <= fwd && (fwd_sel == SEL_SCYTALE);
            data1_o      <= (fwd && (fwd_sel == SEL_SCYTALE)) ? data_i : '0;
            valid2_o     <= fwd && (fwd_sel == SEL_ZIGZAG);
            data2_o      <= (fwd && (fwd_sel == SEL_ZIGZAG))  ? data_i : '0;
        end
    end
endmodule

// File: tb/tb_decryption_scheduler.sv
module tb_decryption_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_i = '0;
    logic       valid_i = 1'b0;
    logic [1:0] select_i = '0;
    logic       busy_o;
    logic [7:0] data0_o, data1_o, data2_o;
    logic       valid0_o, valid1_o, valid2_o;
    logic       busy0_i = 1'b0, busy1_i = 1'b0, busy2_i = 1'b0;
    logic [1:0] mux_select_o;
    logic [7:0] msg_len_o;
    logic       err_o;

    typedef struct {
        int         ch;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    decryption_scheduler #(
        .D_WIDTH(8), .TERMINATOR(8'hFA), .LEN_W(8), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
        .select_i(select_i), .busy_o(busy_o),
        .data0_o(data0_o), .valid0_o(valid0_o),
        .data1_o(data1_o), .valid1_o(valid1_o),
        .data2_o(data2_o), .valid2_o(valid2_o),
        .busy0_i(busy0_i), .busy1_i(busy1_i), .busy2_i(busy2_i),
        .mux_select_o(mux_select_o), .msg_len_o(msg_len_o), .err_o(err_o)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one byte for one cycle; expected routing is queued when ch >= 0
    task automatic send(input logic [1:0] sel, input logic [7:0] d, input int ch);
        exp_t e;
        select_i = sel;
        data_i   = d;
        valid_i  = 1'b1;
        if (ch >= 0) begin
            e.ch = ch;
            e.d  = d;
            exp_q.push_back(e);
        end
        tick();
        valid_i = 1'b0;
        data_i  = '0;
    endtask

    // monitor: every presented output byte is matched against the queue
    initial begin
        exp_t e;
        logic [7:0] dv[3];
        logic       vv[3];
        forever begin
            @(negedge clk);
            if (rst_n) begin
                dv[0] = data0_o; dv[1] = data1_o; dv[2] = data2_o;
                vv[0] = valid0_o; vv[1] = valid1_o; vv[2] = valid2_o;
                for (int c = 0; c < 3; c++) begin
                    if (vv[c]) begin
                        if (exp_q.size() == 0) begin
                            check($sformatf("unexpected_valid%0d", c), 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("route_channel", c, e.ch);
                            check("route_data", int'(dv[c]), int'(e.d));
                        end
                    end else begin
                        check($sformatf("idle_data%0d_zero", c), int'(dv[c]), 0);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        #12;
        check("rst_busy", busy_o, 0);
        check("rst_mux", mux_select_o, 3);
        check("rst_len", msg_len_o, 0);
        check("rst_err", err_o, 0);
        check("rst_valid", {valid0_o, valid1_o, valid2_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // message to Scytale
        send(2'd1, 8'h41, 1);
        check("m1_mux_first", mux_select_o, 1);
        check("m1_busy_low", busy_o, 0);
        send(2'd1, 8'h42, 1);
        send(2'd1, 8'hFA, 1);
        check("m1_len", msg_len_o, 3);
        check("m1_busy_rise", busy_o, 1);
        check("m1_mux_drain", mux_select_o, 1);
        busy1_i = 1'b1;
        repeat (4) tick();
        check("m1_busy_during", busy_o, 1);
        busy1_i = 1'b0;
        tick();
        check("m1_flush_busy", busy_o, 1);
        check("m1_flush_mux", mux_select_o, 1);
        tick();
        check("m1_idle_busy", busy_o, 0);
        check("m1_idle_mux", mux_select_o, 3);

        // message to ZigZag, foreign busy ignored, byte dropped in DRAIN
        send(2'd2, 8'h10, 2);
        check("m2_mux", mux_select_o, 2);
        send(2'd2, 8'hFA, 2);
        check("m2_len", msg_len_o, 2);
        busy0_i = 1'b1;
        repeat (2) tick();
        busy0_i = 1'b0;
        repeat (2) tick();
        check("m2_foreign_busy", busy_o, 1);
        send(2'd0, 8'h77, -1);
        check("m2_drop_err", err_o, 1);
        check("m2_drop_busy", busy_o, 1);
        tick();
        check("m2_err_single", err_o, 0);
        busy2_i = 1'b1;
        repeat (2) tick();
        busy2_i = 1'b0;
        tick();
        check("m2_flush", busy_o, 1);
        tick();
        check("m2_idle", busy_o, 0);

        // invalid select
        send(2'd3, 8'h55, -1);
        check("inv_err", err_o, 1);
        check("inv_mux", mux_select_o, 3);
        check("inv_busy", busy_o, 0);
        tick();
        check("inv_err_single", err_o, 0);

        // one-byte message then drain timeout
        send(2'd0, 8'hFA, 0);
        check("to_len1", msg_len_o, 1);
        check("to_busy", busy_o, 1);
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            check("to_no_early_err", err_o, 0);
            tick();
        end
        check("to_drain_cycles", n, 16);
        check("to_err", err_o, 1);
        check("to_mux", mux_select_o, 3);
        tick();
        check("to_err_single", err_o, 0);

        // select change mid-message stays on channel 0
        send(2'd0, 8'h01, 0);
        send(2'd2, 8'h02, 0);
        check("mid_mux", mux_select_o, 0);
        send(2'd2, 8'hFA, 0);
        check("mid_len", msg_len_o, 3);
        busy0_i = 1'b1;
        tick();
        busy0_i = 1'b0;
        repeat (2) tick();
        check("mid_idle", busy_o, 0);

        // async reset mid-ROUTE
        send(2'd1, 8'h33, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid1", valid1_o, 0);
        check("arst_data1", data1_o, 0);
        check("arst_mux", mux_select_o, 3);
        check("arst_busy", busy_o, 0);
        check("arst_len", msg_len_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        send(2'd2, 8'h5A, 2);
        check("post_mux", mux_select_o, 2);
        send(2'd2, 8'hFA, 2);
        check("post_len", msg_len_o, 2);
        busy2_i = 1'b1;
        tick();
        busy2_i = 1'b0;
        repeat (2) tick();
        check("post_idle", busy_o, 0);

        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/decryption_scheduler.md
Name: decryption_scheduler

Overview:
Front-end controller for the decryption system. It accepts the encrypted byte stream together with a per-message algorithm select and routes each message to exactly one of the three decryptors (Caesar, Scytale, ZigZag). It back-pressures the source while the chosen decryptor drains, and drives the output mux select so the decrypted bytes reach the system output. A drain watchdog aborts any message whose decryptor never completes.

Parameters:
D_WIDTH, 8, data byte width
TERMINATOR, 8'hFA, end-of-message marker byte; it is forwarded to the decryptor
LEN_W, 8, width of the message length counter
TIMEOUT, 1023, maximum cycles allowed in DRAIN before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset; one clock domain only
data_i  in  D_WIDTH  encrypted input byte
valid_i  in  1  input byte strobe
select_i  in  2  algorithm for the message: 0 Caesar, 1 Scytale, 2 ZigZag, 3 invalid
busy_o  out  1  source must not assert valid_i while high
data0_o/valid0_o  out  D_WIDTH/1  Caesar decryptor input
data1_o/valid1_o  out  D_WIDTH/1  Scytale decryptor input
data2_o/valid2_o  out  D_WIDTH/1  ZigZag decryptor input
busy0_i, busy1_i, busy2_i  in  1 each  decryptor busy (high while emitting plaintext)
mux_select_o  out  2  select driven to the output mux; 3 = outputs disabled
msg_len_o  out  LEN_W  byte count of the last routed message, terminator included
err_o  out  1  one-cycle error pulse

Behaviour:
- Reset (async, rst_n low) drives every output to 0, except mux_select_o = 2'b11. State = IDLE, latched select = 3, all counters = 0. A reset in mid-message discards the message immediately; no terminator is synthesised.
- All outputs are registered.
- Routing:
  - An accepted byte appears on dataX_o/validX_o exactly 1 cycle after valid_i, where X is the latched select.
  - Non-selected channels hold data = 0 and valid = 0.
  - dataX_o = 0 whenever validX_o = 0.
- States:
  - IDLE:
    - busy_o = 0 and mux_select_o = 3.
    - valid_i with select_i in 0..2: latch the select, forward the byte, set the length counter to 1, go to ROUTE.
    - If that byte equals TERMINATOR, go directly to DRAIN (message length 1).
    - valid_i with select_i = 3: drop the byte, pulse err_o, stay in IDLE.
  - ROUTE:
    - mux_select_o = latched select.
    - select_i is ignored for the rest of the message.
    - Each valid_i byte is forwarded and the length counter increments, saturating at 2^LEN_W - 1.
    - When the accepted byte equals TERMINATOR: msg_len_o is updated on the same edge the byte is forwarded, and the next state is DRAIN.
  - DRAIN:
    - busy_o = 1, mux_select_o held, watchdog counts from 0.
    - Waits to see busyX_i rise and then fall. The fall goes to FLUSH.
    - A rise and fall on a non-selected busy input is ignored.
    - Watchdog reaching TIMEOUT: pulse err_o and go to IDLE.
  - FLUSH:
    - Exactly 1 cycle with busy_o = 1 and mux_select_o held, so the last plaintext byte passes through the registered mux.
    - Then go to IDLE.
- busy_o is registered. It rises on the cycle after the terminator is accepted and falls on entry to IDLE.
- valid_i while busy_o = 1: the byte is dropped, err_o pulses, and the state is unaffected.
- err_o sources coinciding in the same cycle produce a single one-cycle pulse.
- The upstream source may issue back-to-back messages. A new message is accepted on the first cycle in which busy_o is observed low.

Decomposition:
- Shared package (decryption_pkg):
  - state enum: IDLE, ROUTE, DRAIN, FLUSH
  - select codes: SEL_CAESAR=0, SEL_SCYTALE=1, SEL_ZIGZAG=2, SEL_NONE=3
  - default TERMINATOR and D_WIDTH
- One sub-module, drain_watchdog: a clearable, enabled counter with a terminal-count flag at TIMEOUT. It is instantiated once for DRAIN. The FSM and routing stay in the top level.

Test Plan:
- Reset then select_i=1, send bytes 8'h41, 8'h42, 8'hFA -> valid1_o carries 41, 42, FA at +1 cycle each; valid0_o and valid2_o stay 0; msg_len_o=3; busy_o rises the cycle after FA; mux_select_o=1 from the first byte.
- Continuing: busy1_i high 4 cycles then low -> FLUSH for 1 cycle, then busy_o=0 and mux_select_o=3; a new message with select_i=2 is routed to channel 2.
- select_i=3 with valid_i, byte 8'h55 -> all validX_o stay 0, err_o pulses once, state remains IDLE.
- TIMEOUT=16, message terminated, busyX_i never rises -> err_o pulses on the 16th DRAIN cycle; return to IDLE; busy_o=0.
- valid_i pulsed during DRAIN -> byte dropped, err_o pulses, and the normal drain completes. Separately: select_i changed mid-message from 0 to 2 -> bytes still go to channel 0.
- rst_n asserted asynchronously mid-ROUTE (between clock edges) -> all outputs are 0 and mux_select_o=3 immediately. After release, the next message routes correctly.
